// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared types, widths and helpers for the triangle rasterizer
package raster_pkg;

    localparam int COORD_W = 9;
    localparam int COLOR_W = 8;
    localparam int EDGE_W  = 2 * (COORD_W + 1) + 1;

    typedef logic [COORD_W-1:0] coord_t;

    // x sits in the low bits so the packed layout matches a [2:0] x COORD_W port with [0]=x
    typedef struct packed {
        coord_t z;
        coord_t y;
        coord_t x;
    } vertex_t;

    typedef logic signed [EDGE_W-1:0] edge_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } rast_state_t;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/edge_eval.sv
// rtl/edge_eval.sv - combinational edge function E(a,b,p), full precision
module edge_eval
    import raster_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W-1:0] p_x,
    input  logic [COORD_W-1:0] p_y,
    output edge_t              e
);

    logic signed [COORD_W:0] d_px, d_py, d_bx, d_by;
    edge_t prod_a, prod_b;

    // Zero-extended unsigned coordinates keep every difference inside COORD_W+1 signed bits
    assign d_px = $signed({1'b0, p_x}) - $signed({1'b0, a_x});
    assign d_py = $signed({1'b0, p_y}) - $signed({1'b0, a_y});
    assign d_bx = $signed({1'b0, b_x}) - $signed({1'b0, a_x});
    assign d_by = $signed({1'b0, b_y}) - $signed({1'b0, a_y});

    assign prod_a = EDGE_W'(d_px) * EDGE_W'(d_by);
    assign prod_b = EDGE_W'(d_py) * EDGE_W'(d_bx);
    assign e      = prod_a - prod_b;

endmodule

// File: rtl/tri_rasterizer.sv
// rtl/tri_rasterizer.sv - flat-shaded triangle scan converter over a clipped bounding box
module tri_rasterizer
    import raster_pkg::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    data_valid_in,
    output logic                    ready_out,
    input  logic [2:0][COORD_W-1:0] v1_in,
    input  logic [2:0][COORD_W-1:0] v2_in,
    input  logic [2:0][COORD_W-1:0] v3_in,
    input  logic [COLOR_W-1:0]      color_in,
    output logic                    pixel_valid_out,
    input  logic                    pixel_ready_in,
    output logic [COORD_W-1:0]      pixel_x_out,
    output logic [COORD_W-1:0]      pixel_y_out,
    output logic [COLOR_W-1:0]      color_out,
    output logic                    done_out
);

    localparam coord_t X_LAST = COORD_W'(SCREEN_W - 1);
    localparam coord_t Y_LAST = COORD_W'(SCREEN_H - 1);

    rast_state_t state, state_nxt;
    vertex_t v1, v2, v3;
    logic [COLOR_W-1:0] color_q;
    coord_t xmin, xmax, ymin, ymax, cur_x, cur_y;
    coord_t bx_min, bx_max, by_min, by_max;
    edge_t e0, e1, e2;
    coord_t e0_px, e0_py;
    logic covered, slot_free, at_last, degenerate, load_pix, advance;
    logic z_unused;

    assign z_unused = ^{v1_in[2], v2_in[2], v3_in[2]};

    // Instance 0 doubles as the area evaluator during SETUP by probing v3
    assign e0_px = (state == ST_SETUP) ? v3.x : cur_x;
    assign e0_py = (state == ST_SETUP) ? v3.y : cur_y;

    edge_eval u_e0 (.a_x(v1.x), .a_y(v1.y), .b_x(v2.x), .b_y(v2.y), .p_x(e0_px), .p_y(e0_py), .e(e0));
    edge_eval u_e1 (.a_x(v2.x), .a_y(v2.y), .b_x(v3.x), .b_y(v3.y), .p_x(cur_x), .p_y(cur_y), .e(e1));
    edge_eval u_e2 (.a_x(v3.x), .a_y(v3.y), .b_x(v1.x), .b_y(v1.y), .p_x(cur_x), .p_y(cur_y), .e(e2));

    // Accept either winding; zero on an edge counts as inside
    assign covered = (!e0[EDGE_W-1] && !e1[EDGE_W-1] && !e2[EDGE_W-1]) ||
                     ((e0[EDGE_W-1] || e0 == '0) && (e1[EDGE_W-1] || e1 == '0) &&
                      (e2[EDGE_W-1] || e2 == '0));

    assign bx_min = min3(v1.x, v2.x, v3.x);
    assign by_min = min3(v1.y, v2.y, v3.y);
    assign bx_max = (max3(v1.x, v2.x, v3.x) > X_LAST) ? X_LAST : max3(v1.x, v2.x, v3.x);
    assign by_max = (max3(v1.y, v2.y, v3.y) > Y_LAST) ? Y_LAST : max3(v1.y, v2.y, v3.y);
    assign degenerate = (e0 == '0) || (bx_min > X_LAST) || (by_min > Y_LAST);

    assign slot_free = !pixel_valid_out || pixel_ready_in;
    assign at_last   = (cur_x == xmax) && (cur_y == ymax);
    assign ready_out = (state == ST_IDLE);
    assign done_out  = (state == ST_DONE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_pix  = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE:  if (data_valid_in) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = degenerate ? ST_DONE : ST_SCAN;
            ST_SCAN: begin
                load_pix = covered && slot_free;
                advance  = !covered || slot_free;
                if (advance && at_last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: if (slot_free) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1 <= '0; v2 <= '0; v3 <= '0; color_q <= '0;
            xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
            cur_x <= '0; cur_y <= '0;
            pixel_valid_out <= 1'b0;
            pixel_x_out <= '0; pixel_y_out <= '0; color_out <= '0;
        end else begin
            if (state == ST_IDLE && data_valid_in) begin
                v1 <= v1_in; v2 <= v2_in; v3 <= v3_in;
                color_q <= color_in;
            end
            if (state == ST_SETUP) begin
                xmin <= bx_min; xmax <= bx_max;
                ymin <= by_min; ymax <= by_max;
                cur_x <= bx_min; cur_y <= by_min;
            end
            if (advance) begin
                if (cur_x == xmax) begin
                    cur_x <= xmin;
                    cur_y <= cur_y + 1'b1;
                end else begin
                    cur_x <= cur_x + 1'b1;
                end
            end
            if (load_pix) begin
                pixel_x_out <= cur_x;
                pixel_y_out <= cur_y;
                color_out   <= color_q;
                pixel_valid_out <= 1'b1;
            end else if (pixel_ready_in) begin
                pixel_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tri_rasterizer.sv
// tb/tb_tri_rasterizer.sv - randomized self-checking bench for tri_rasterizer
module tb_tri_rasterizer;

    logic              clk_in = 1'b0;
    logic              rst_n_in = 1'b0;
    logic              data_valid_in = 1'b0;
    logic              ready_out;
    logic [2:0][8:0]   v1_in = '0, v2_in = '0, v3_in = '0;
    logic [7:0]        color_in = '0;
    logic              pixel_valid_out;
    logic              pixel_ready_in = 1'b1;
    logic [8:0]        pixel_x_out, pixel_y_out;
    logic [7:0]        color_out;
    logic              done_out;

    tri_rasterizer #(.SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_valid_in(data_valid_in),
        .ready_out(ready_out), .v1_in(v1_in), .v2_in(v2_in), .v3_in(v3_in),
        .color_in(color_in), .pixel_valid_out(pixel_valid_out),
        .pixel_ready_in(pixel_ready_in), .pixel_x_out(pixel_x_out),
        .pixel_y_out(pixel_y_out), .color_out(color_out), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0, bad = 0;
    int cyc = 0, c0 = 0, rdy_mode = 0, rdy_idx = 0;
    int px_q[$], py_q[$], pc_q[$], ex_q[$], ey_q[$];
    int done_cnt, done_cyc, first_pv_cyc, last_acc_cyc, stall_err;
    bit stall_pend;
    int st_x, st_y, st_c;
    int tx[3], ty[3], tc;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial forever begin
        @(posedge clk_in);
        #1;
        rdy_idx++;
        case (rdy_mode)
            0:       pixel_ready_in = 1'b1;
            1:       pixel_ready_in = (rdy_idx % 3 == 0);
            default: pixel_ready_in = 1'($urandom_range(0, 1));
        endcase
    end

    // Pixel is taken at the next rising edge when valid and ready are both seen here
    initial forever begin
        @(negedge clk_in);
        if (!rst_n_in) stall_pend = 0;
        if (pixel_valid_out) begin
            if (first_pv_cyc < 0) first_pv_cyc = cyc;
            if (stall_pend && (pixel_x_out != st_x || pixel_y_out != st_y || color_out != st_c))
                stall_err++;
            if (pixel_ready_in) begin
                px_q.push_back(pixel_x_out); py_q.push_back(pixel_y_out); pc_q.push_back(color_out);
                last_acc_cyc = cyc;
                stall_pend = 0;
            end else begin
                stall_pend = 1;
                st_x = pixel_x_out; st_y = pixel_y_out; st_c = color_out;
            end
        end else begin
            if (stall_pend) stall_err++;
            stall_pend = 0;
        end
        if (done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic int edge_f(int ax, int ay, int bx, int by, int px, int py);
        return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
    endfunction

    task automatic build_expected();
        int xmin, xmax, ymin, ymax, e0, e1, e2;
        ex_q.delete(); ey_q.delete();
        xmin = tx[0]; xmax = tx[0]; ymin = ty[0]; ymax = ty[0];
        for (int i = 1; i < 3; i++) begin
            if (tx[i] < xmin) xmin = tx[i];
            if (tx[i] > xmax) xmax = tx[i];
            if (ty[i] < ymin) ymin = ty[i];
            if (ty[i] > ymax) ymax = ty[i];
        end
        if (xmax > 319) xmax = 319;
        if (ymax > 239) ymax = 239;
        if (edge_f(tx[0], ty[0], tx[1], ty[1], tx[2], ty[2]) == 0) return;
        for (int y = ymin; y <= ymax; y++)
            for (int x = xmin; x <= xmax; x++) begin
                e0 = edge_f(tx[0], ty[0], tx[1], ty[1], x, y);
                e1 = edge_f(tx[1], ty[1], tx[2], ty[2], x, y);
                e2 = edge_f(tx[2], ty[2], tx[0], ty[0], x, y);
                if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
                    ex_q.push_back(x); ey_q.push_back(y);
                end
            end
    endtask

    task automatic start_tri(input int x1, input int y1, input int x2, input int y2,
                             input int x3, input int y3, input int col, input int mode);
        @(posedge clk_in);
        #1;
        rdy_mode = mode;
        px_q.delete(); py_q.delete(); pc_q.delete();
        done_cnt = 0; done_cyc = -1; first_pv_cyc = -1; last_acc_cyc = -1;
        stall_err = 0; stall_pend = 0;
        tx[0] = x1; ty[0] = y1; tx[1] = x2; ty[1] = y2; tx[2] = x3; ty[2] = y3; tc = col;
        v1_in = {9'($urandom), 9'(y1), 9'(x1)};
        v2_in = {9'($urandom), 9'(y2), 9'(x2)};
        v3_in = {9'($urandom), 9'(y3), 9'(x3)};
        color_in = 8'(col);
        data_valid_in = 1'b1;
        @(negedge clk_in);
        chk("ready_idle", int'(ready_out), 1);
        c0 = cyc;
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
        color_in = 8'($urandom);
        build_expected();
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk_in);
            if (done_cnt > 0) break;
        end
        if (n == 4000) chk("done_timeout", 0, 1);
        @(negedge clk_in);
        chk("ready_after_done", int'(ready_out), 1);
        @(negedge clk_in);
        chk("done_pulse_count", done_cnt, 1);
    endtask

    task automatic check_result(input string tag);
        int n;
        chk({tag, "_count"}, px_q.size(), ex_q.size());
        n = (px_q.size() < ex_q.size()) ? px_q.size() : ex_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_x"}, px_q[i], ex_q[i]);
            chk({tag, "_y"}, py_q[i], ey_q[i]);
            chk({tag, "_c"}, pc_q[i], tc);
        end
        chk({tag, "_stall"}, stall_err, 0);
        if (ex_q.size() > 0) chk({tag, "_done_after_last"}, int'(done_cyc > last_acc_cyc), 1);
    endtask

    initial begin
        int xb, yb, mx, n;
        repeat (3) @(negedge clk_in);
        chk("rst_ready", int'(ready_out), 1);
        chk("rst_valid", int'(pixel_valid_out), 0);
        chk("rst_done", int'(done_out), 0);
        chk("rst_x", int'(pixel_x_out), 0);
        chk("rst_y", int'(pixel_y_out), 0);
        chk("rst_color", int'(color_out), 0);
        rst_n_in = 1'b1;

        start_tri(0, 0, 3, 0, 0, 3, 'hA5, 0);
        wait_done();
        check_result("right");
        chk("right_first_valid_lat", first_pv_cyc - c0, 3);
        chk("right_expect_len", ex_q.size(), 10);

        start_tri(0, 0, 0, 3, 3, 0, 'hA5, 0);
        wait_done();
        check_result("reversed");

        start_tri(0, 0, 2, 2, 4, 4, 'h3C, 0);
        wait_done();
        check_result("collinear");
        chk("collinear_done_lat", done_cyc - c0, 2);

        start_tri(0, 0, 3, 0, 0, 3, 'hA5, 1);
        wait_done();
        check_result("stall");

        start_tri(318, 0, 330, 0, 318, 12, 'h11, 2);
        wait_done();
        check_result("clip");
        mx = 0;
        foreach (px_q[i]) if (px_q[i] > mx) mx = px_q[i];
        chk("clip_max_x", int'(mx < 320), 1);

        start_tri(0, 0, 3, 0, 0, 3, 'hA5, 0);
        for (n = 0; n < 200; n++) begin
            @(negedge clk_in);
            if (pixel_valid_out && px_q.size() >= 3) break;
        end
        chk("mid_scan_reached", int'(n < 200), 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_valid", int'(pixel_valid_out), 0);
        chk("async_rst_ready", int'(ready_out), 1);
        repeat (3) @(negedge clk_in);
        chk("async_rst_no_done", done_cnt, 0);
        rst_n_in = 1'b1;
        start_tri(5, 5, 5, 5, 6, 6, 'h77, 0);
        wait_done();
        check_result("post_reset");

        for (int t = 0; t < 12; t++) begin
            xb = $urandom_range(0, 330);
            yb = $urandom_range(0, 250);
            if (t % 5 == 4)
                start_tri(xb, yb, xb + 4, yb + 4, xb + 8, yb + 8, $urandom_range(0, 255), t % 3);
            else
                start_tri(xb + $urandom_range(0, 14), yb + $urandom_range(0, 14),
                          xb + $urandom_range(0, 14), yb + $urandom_range(0, 14),
                          xb + $urandom_range(0, 14), yb + $urandom_range(0, 14),
                          $urandom_range(0, 255), t % 3);
            wait_done();
            check_result("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
